// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: one-hot frame states (also decoded
// by the byte analyser) and the oversample positions at which each stage acts.
package uart_rx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_STARTBIT  = 5'b00010,
        ST_DATABITS  = 5'b00100,
        ST_PARITYBIT = 5'b01000,
        ST_STOPBIT   = 5'b10000
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int ACQ_POINT_DEFAULT  = 7;

    // Downstream stages act one tick apart after the acquisition point.
    localparam int PARITY_JUDGE_POINT = ACQ_POINT_DEFAULT + 1;
    localparam int DATA_POINT         = ACQ_POINT_DEFAULT + 2;
    localparam int FIFO_POINT         = ACQ_POINT_DEFAULT + 3;

endpackage

// File: rtl/uart_rx_input_filter.sv
// Two-flop synchroniser for the async rx line plus a 3-sample majority vote over the
// ticks at ACQ_POINT-2, ACQ_POINT-1 and ACQ_POINT of the current bit.
module uart_rx_input_filter #(
    parameter int CW        = 4,
    parameter int ACQ_POINT = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          rx,
    input  logic [CW-1:0] cnt,
    output logic          line,
    output logic          majority
);
    localparam logic [CW-1:0] EARLY_CNT = CW'(ACQ_POINT - 2);
    localparam logic [CW-1:0] MID_CNT   = CW'(ACQ_POINT - 1);

    logic sync_a;
    logic sync_b;
    logic early;
    logic mid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            early  <= 1'b1;
            mid    <= 1'b1;
        end else begin
            sync_a <= rx;
            sync_b <= sync_a;
            if (tick && (cnt == EARLY_CNT)) early <= sync_b;
            if (tick && (cnt == MID_CNT))   mid   <= sync_b;
        end
    end

    // Third vote is the live synchronised line on the acquisition tick itself.
    assign line     = sync_b;
    assign majority = (early & mid) | (early & sync_b) | (mid & sync_b);

endmodule

// File: rtl/uart_rx_frame_fsm.sv
// Receive frame sequencer: walks START/DATA/PARITY/STOP on oversample ticks and
// hands each data/parity bit to the rx shift register as a one-clock strobe.
module uart_rx_frame_fsm
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int ACQ_POINT  = ACQ_POINT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_Baud16Tick_i,
    input  logic                          rx_i,
    input  logic                          p_RxEnable_i,
    input  logic                          p_ParityEnable_i,
    output logic [4:0]                    State_o,
    output logic [$clog2(OVERSAMPLE)-1:0] BitWidthCnt_o,
    output logic                          Bit_Synch_o,
    output logic                          Bit_o,
    output logic                          p_FrameError_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] ACQ_CNT   = CW'(ACQ_POINT);
    localparam logic [CW-1:0] LAST_CNT  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] LEAVE_CNT = CW'(ACQ_POINT + 3);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    rx_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [IW-1:0] bit_idx, idx_next;
    logic          armed, armed_next;
    logic          frame_error, ferr_next;
    logic          bit_synch, synch_next;
    logic          bit_value, bit_next;
    logic          line;
    logic          majority;
    logic          at_acq;
    logic          at_last;

    uart_rx_input_filter #(
        .CW        (CW),
        .ACQ_POINT (ACQ_POINT)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .tick     (p_Baud16Tick_i),
        .rx       (rx_i),
        .cnt      (cnt),
        .line     (line),
        .majority (majority)
    );

    assign at_acq  = (cnt == ACQ_CNT);
    assign at_last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            armed       <= 1'b1;
            frame_error <= 1'b0;
            bit_synch   <= 1'b0;
            bit_value   <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= idx_next;
            armed       <= armed_next;
            frame_error <= ferr_next;
            bit_synch   <= synch_next;
            bit_value   <= bit_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        armed_next = armed;
        ferr_next  = frame_error;
        synch_next = 1'b0;
        bit_next   = bit_value;
        // A disable takes precedence over everything, including a pending strobe.
        if (!p_RxEnable_i) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (p_Baud16Tick_i) begin
            cnt_next = at_last ? '0 : cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    cnt_next = '0;
                    if (line) begin
                        armed_next = 1'b1;
                    end else if (armed) begin
                        state_next = ST_STARTBIT;
                        ferr_next  = 1'b0;
                    end
                end
                ST_STARTBIT: begin
                    if (at_acq && majority) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (at_last) begin
                        state_next = ST_DATABITS;
                        idx_next   = '0;
                    end
                end
                ST_DATABITS: begin
                    if (at_acq) begin
                        synch_next = 1'b1;
                        bit_next   = majority;
                    end
                    if (at_last) begin
                        if (bit_idx == LAST_IDX) begin
                            state_next = p_ParityEnable_i ? ST_PARITYBIT : ST_STOPBIT;
                        end else begin
                            idx_next = bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITYBIT: begin
                    if (at_acq) begin
                        synch_next = 1'b1;
                        bit_next   = majority;
                    end
                    if (at_last) state_next = ST_STOPBIT;
                end
                ST_STOPBIT: begin
                    if (at_acq && !majority) begin
                        ferr_next  = 1'b1;
                        armed_next = 1'b0;
                    end
                    // Leaving here means cnt never shows ACQ_POINT+4 in STOPBIT,
                    // leaving headroom for an early next start edge.
                    if (cnt == LEAVE_CNT) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Bit_Synch_o is valid-only (no ready): Bit_o is meaningful in the single clock
    // where Bit_Synch_o is high, and the consumer must take it then.
    assign State_o        = state;
    assign BitWidthCnt_o  = cnt;
    assign Bit_Synch_o    = bit_synch;
    assign Bit_o          = bit_value;
    assign p_FrameError_o = frame_error;

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Bench for uart_rx_frame_fsm: drives serial frames at 16 ticks/bit (tick every 4 clk)
// and scoreboards every bit strobe against frame-level expectations.
module tb_uart_rx_frame_fsm;

  localparam int TICK_CLKS = 4;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_START  = 5'b00010;
  localparam logic [4:0] S_DATA   = 5'b00100;
  localparam logic [4:0] S_PARITY = 5'b01000;
  localparam logic [4:0] S_STOP   = 5'b10000;

  localparam logic [31:0] PATH_FRAME  = {12'd0, S_START, S_DATA, S_STOP, S_IDLE};
  localparam logic [31:0] PATH_PARITY = {7'd0, S_START, S_DATA, S_PARITY, S_STOP, S_IDLE};
  localparam logic [31:0] PATH_FALSE  = {22'd0, S_START, S_IDLE};

  logic       clk;
  logic       rst;
  logic       p_Baud16Tick_i;
  logic       rx_i;
  logic       p_RxEnable_i;
  logic       p_ParityEnable_i;
  logic [4:0] State_o;
  logic [3:0] BitWidthCnt_o;
  logic       Bit_Synch_o;
  logic       Bit_o;
  logic       p_FrameError_o;

  int checks = 0;
  int failures = 0;
  int fe_expected = 0;
  int fe_seen = 0;

  // Expected strobes: {state the strobe must occur in, bit value}.
  logic [5:0] exp_q[$];

  logic [31:0] path_word = '0;
  logic [3:0]  stop_max = '0;
  logic [3:0]  false_cnt = '0;
  logic [4:0]  prev_state = S_IDLE;
  logic [3:0]  prev_cnt = '0;
  logic        prev_synch = 1'b0;
  logic        prev_fe = 1'b0;

  uart_rx_frame_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .p_Baud16Tick_i   (p_Baud16Tick_i),
    .rx_i             (rx_i),
    .p_RxEnable_i     (p_RxEnable_i),
    .p_ParityEnable_i (p_ParityEnable_i),
    .State_o          (State_o),
    .BitWidthCnt_o    (BitWidthCnt_o),
    .Bit_Synch_o      (Bit_Synch_o),
    .Bit_o            (Bit_o),
    .p_FrameError_o   (p_FrameError_o)
  );

  // clock / tick generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    p_Baud16Tick_i = 1'b0;
    forever begin
      repeat (TICK_CLKS - 1) @(negedge clk);
      p_Baud16Tick_i = 1'b1;
      @(negedge clk);
      p_Baud16Tick_i = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic hold_line(input logic v, input int clks);
    rx_i = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_en,
                            input logic par_val, input logic stop_val);
    p_ParityEnable_i = par_en;
    for (int i = 0; i < 8; i++) exp_q.push_back({S_DATA, data[i]});
    if (par_en) exp_q.push_back({S_PARITY, par_val});
    if (!stop_val) fe_expected++;
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_line(data[i], BIT_CLKS);
    if (par_en) hold_line(par_val, BIT_CLKS);
    hold_line(stop_val, BIT_CLKS);
    check("frame_error_level", p_FrameError_o, !stop_val);
    hold_line(1'b1, 2 * BIT_CLKS);
    check("exp_queue_drained", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst) begin
      if (Bit_Synch_o) begin
        check("strobe_single_clk", prev_synch, 1'b0);
        check("strobe_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("strobe_bit", Bit_o, e[0]);
          check("strobe_state", State_o, e[5:1]);
        end
      end
      if (p_FrameError_o && !prev_fe) fe_seen++;
      if (State_o != prev_state) begin
        path_word = {path_word[26:0], State_o};
        if (State_o == S_START) check("fe_clear_on_start", p_FrameError_o, 1'b0);
        if (prev_state == S_START && State_o == S_IDLE) false_cnt = prev_cnt;
      end
      if (State_o == S_STOP && BitWidthCnt_o > stop_max) stop_max = BitWidthCnt_o;
      prev_state = State_o;
      prev_cnt   = BitWidthCnt_o;
      prev_synch = Bit_Synch_o;
      prev_fe    = p_FrameError_o;
    end
  end

  // stimulus
  initial begin
    logic [7:0] d;
    rst = 1'b0;
    rx_i = 1'b1;
    p_RxEnable_i = 1'b1;
    p_ParityEnable_i = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_state", State_o, S_IDLE);
    check("reset_cnt", BitWidthCnt_o, 4'd0);
    check("reset_synch", Bit_Synch_o, 1'b0);
    check("reset_bit", Bit_o, 1'b1);
    check("reset_fe", p_FrameError_o, 1'b0);
    rst = 1'b1;
    hold_line(1'b1, BIT_CLKS);

    // plain frame
    path_word = '0;
    stop_max = '0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_path", path_word, PATH_FRAME);
    check("a5_stop_max_cnt", stop_max, 4'd10);

    // false start
    path_word = '0;
    false_cnt = '0;
    hold_line(1'b0, 4 * TICK_CLKS);
    hold_line(1'b1, 2 * BIT_CLKS);
    check("false_start_path", path_word, PATH_FALSE);
    check("false_start_cnt", false_cnt, 4'd7);
    check("false_start_fe", p_FrameError_o, 1'b0);

    // frame error, kept across a disable, cleared by next start
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    p_RxEnable_i = 1'b0;
    repeat (8) @(negedge clk);
    check("fe_kept_on_disable", p_FrameError_o, 1'b1);
    p_RxEnable_i = 1'b1;
    hold_line(1'b1, BIT_CLKS);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);

    // break
    path_word = '0;
    for (int i = 0; i < 8; i++) exp_q.push_back({S_DATA, 1'b0});
    fe_expected++;
    hold_line(1'b0, 20 * BIT_CLKS);
    check("break_path", path_word, PATH_FRAME);
    check("break_fe", p_FrameError_o, 1'b1);
    hold_line(1'b1, 2 * BIT_CLKS);
    check("break_drained", exp_q.size(), 0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);

    // parity
    path_word = '0;
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    check("parity_path", path_word, PATH_PARITY);
    p_ParityEnable_i = 1'b0;

    // receiver disabled during data bit 3
    d = 8'hB6;
    for (int i = 0; i < 3; i++) exp_q.push_back({S_DATA, d[i]});
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) hold_line(d[i], BIT_CLKS);
    hold_line(d[3], 2 * TICK_CLKS);
    p_RxEnable_i = 1'b0;
    @(negedge clk);
    check("disable_state", State_o, S_IDLE);
    check("disable_cnt", BitWidthCnt_o, 4'd0);
    hold_line(d[3], BIT_CLKS - 2 * TICK_CLKS - 1);
    for (int i = 4; i < 8; i++) hold_line(d[i], BIT_CLKS);
    hold_line(1'b1, 2 * BIT_CLKS);
    check("disabled_idle", State_o, S_IDLE);
    check("disable_drained", exp_q.size(), 0);
    p_RxEnable_i = 1'b1;
    hold_line(1'b1, BIT_CLKS);
    send_frame(8'h6E, 1'b0, 1'b0, 1'b1);

    // async reset mid-frame
    d = 8'h9A;
    for (int i = 0; i < 2; i++) exp_q.push_back({S_DATA, d[i]});
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 2; i++) hold_line(d[i], BIT_CLKS);
    hold_line(d[2], 5 * TICK_CLKS);
    rst = 1'b0;
    #1;
    check("async_reset_state", State_o, S_IDLE);
    check("async_reset_cnt", BitWidthCnt_o, 4'd0);
    check("async_reset_bit", Bit_o, 1'b1);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    hold_line(1'b1, 2 * BIT_CLKS);
    check("reset_drained", exp_q.size(), 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);

    // randomized frames
    for (int n = 0; n < 12; n++) begin
      hold_line(1'b1, $urandom_range(0, 2 * BIT_CLKS));
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
    end

    check("fe_event_count", fe_seen, fe_expected);
    check("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
